// File: rtl/sm_matrix_n_pkg.sv
// Shared definitions for the sm_matrix_n interconnect: FSM states, default address map and
// the read-data value returned with an error response.
package sm_matrix_n_pkg;

   typedef enum logic [1:0] {
      SM_MX_IDLE = 2'd0,
      SM_MX_BUSY = 2'd1,
      SM_MX_ERR  = 2'd2
   } sm_mx_state_e;

   // Scratchpad claims 0x0000_0000..0x1FFF_FFFF; the AHB port is a catch-all (mask 0) that
   // picks up everything from 0x2000_0000 upward when placed at a higher index.
   localparam logic [31:0] DEF_SPM_BASE = 32'h0000_0000;
   localparam logic [31:0] DEF_SPM_MASK = 32'hE000_0000;
   localparam logic [31:0] DEF_AHB_BASE = 32'h0000_0000;
   localparam logic [31:0] DEF_AHB_MASK = 32'h0000_0000;

   localparam logic [31:0] ERR_RD = 32'h0000_0000;

endpackage

// File: rtl/sm_matrix_n_if.sv
// CPU data port plus the fanned-out target bus. The interconnect uses the slave modport;
// the CPU/target environment uses the master modport.
interface sm_matrix_n_if #(
   parameter int SLAVES = 4
);
   logic [31:0]          a;
   logic                 we;
   logic [31:0]          wd;
   logic                 valid;
   logic                 ready;
   logic [31:0]          rd;
   logic                 err;
   logic [31:0]          s_a;
   logic                 s_we;
   logic [31:0]          s_wd;
   logic [SLAVES-1:0]    s_valid;
   logic [SLAVES-1:0]    s_ready;
   logic [32*SLAVES-1:0] s_rd;

   modport master (
      output a, we, wd, valid, s_ready, s_rd,
      input  ready, rd, err, s_a, s_we, s_wd, s_valid
   );

   modport slave (
      input  a, we, wd, valid, s_ready, s_rd,
      output ready, rd, err, s_a, s_we, s_wd, s_valid
   );
endinterface

// File: rtl/sm_matrix_n_decoder.sv
// Address decoder: one-hot select of the lowest-index window that matches, or miss.
module sm_matrix_n_decoder
   import sm_matrix_n_pkg::*;
#(
   parameter int                   SLAVES    = 4,
   parameter logic [32*SLAVES-1:0] ADDR_BASE = {SLAVES{32'h0}},
   parameter logic [32*SLAVES-1:0] ADDR_MASK = {SLAVES{32'h0}}
) (
   input  logic [31:0]       i_a,
   output logic [SLAVES-1:0] o_sel,
   output logic              o_miss
);

   always_comb begin
      o_sel  = '0;
      o_miss = 1'b1;
      for (int unsigned i = 0; i < SLAVES; i++) begin
         if (o_miss && ((i_a & ADDR_MASK[32*i +: 32]) == ADDR_BASE[32*i +: 32])) begin
            o_sel[i] = 1'b1;
            o_miss   = 1'b0;
         end
      end
   end

endmodule

// File: rtl/sm_matrix_n.sv
// Single-outstanding interconnect: decodes the CPU request to one target, waits for its
// response (or a timeout) and steers ready/rd/err back. Unmapped addresses get an error.
module sm_matrix_n
   import sm_matrix_n_pkg::*;
#(
   parameter int                   SLAVES    = 4,
   parameter logic [32*SLAVES-1:0] ADDR_BASE = {SLAVES{32'h0}},
   parameter logic [32*SLAVES-1:0] ADDR_MASK = {SLAVES{32'h0}},
   parameter int                   TIMEOUT   = 255,
   parameter int                   TW        = 8
) (
   input logic           clk,
   input logic           rst_n,
   sm_matrix_n_if.slave  bus
);

   localparam int unsigned    SW      = (SLAVES > 1) ? $clog2(SLAVES) : 1;
   localparam logic [TW-1:0]  TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

   sm_mx_state_e      r_state, w_state_nxt;
   logic [SW-1:0]     r_sel, w_sel_nxt, w_sel_idx;
   logic [TW-1:0]     r_cnt, w_cnt_nxt;
   logic [SLAVES-1:0] w_sel_oh, w_s_valid;
   logic              w_miss, w_ready, w_err;
   logic [31:0]       w_rd;
   logic [31:0]       w_rd_arr [SLAVES];

   sm_matrix_n_decoder #(
      .SLAVES    (SLAVES),
      .ADDR_BASE (ADDR_BASE),
      .ADDR_MASK (ADDR_MASK)
   ) u_decoder (
      .i_a    (bus.a),
      .o_sel  (w_sel_oh),
      .o_miss (w_miss)
   );

   for (genvar g = 0; g < SLAVES; g++) begin : g_rd
      assign w_rd_arr[g] = bus.s_rd[32*g +: 32];
   end

   always_comb begin
      w_sel_idx = '0;
      for (int unsigned i = 0; i < SLAVES; i++) begin
         if (w_sel_oh[i]) w_sel_idx = SW'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SM_MX_IDLE;
         r_sel   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_cnt_nxt   = r_cnt;
      w_s_valid   = '0;
      w_ready     = 1'b0;
      w_err       = 1'b0;
      w_rd        = ERR_RD;
      case (r_state)
         SM_MX_IDLE: begin
            if (bus.valid) begin
               if (w_miss) begin
                  w_state_nxt = SM_MX_ERR;
               end else begin
                  w_s_valid   = w_sel_oh;
                  w_sel_nxt   = w_sel_idx;
                  w_cnt_nxt   = '0;
                  w_state_nxt = SM_MX_BUSY;
               end
            end
         end
         SM_MX_BUSY: begin
            // Selected slave's response takes priority over an expiring timeout.
            if (bus.s_ready[r_sel]) begin
               w_ready     = 1'b1;
               w_rd        = w_rd_arr[r_sel];
               w_state_nxt = SM_MX_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
               if ((TIMEOUT != 0) && (r_cnt == TO_LAST)) begin
                  w_ready     = 1'b1;
                  w_err       = 1'b1;
                  w_state_nxt = SM_MX_IDLE;
               end
            end
         end
         SM_MX_ERR: begin
            w_ready     = 1'b1;
            w_err       = 1'b1;
            w_state_nxt = SM_MX_IDLE;
         end
         default: w_state_nxt = SM_MX_IDLE;
      endcase
   end

   assign bus.s_a     = bus.a;
   assign bus.s_we    = bus.we;
   assign bus.s_wd    = bus.wd;
   assign bus.s_valid = w_s_valid;
   assign bus.ready   = w_ready;
   assign bus.err     = w_err;
   assign bus.rd      = w_rd;

endmodule

// File: tb/tb_sm_matrix_n.sv
// Scenario bench for sm_matrix_n: default-map instance and a no-catch-all, short-timeout instance.
module tb_sm_matrix_n;
   import sm_matrix_n_pkg::*;

   typedef struct {
      logic [31:0] rd;
      logic        err;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   localparam logic [63:0] MAP0_BASE = {DEF_AHB_BASE, DEF_SPM_BASE};
   localparam logic [63:0] MAP0_MASK = {DEF_AHB_MASK, DEF_SPM_MASK};
   localparam logic [63:0] MAP1_BASE = {32'h2000_0000, 32'h0000_0000};
   localparam logic [63:0] MAP1_MASK = {32'hE000_0000, 32'hE000_0000};

   sm_matrix_n_if #(.SLAVES(2)) bus0 ();
   sm_matrix_n_if #(.SLAVES(2)) bus1 ();

   sm_matrix_n #(
      .SLAVES(2), .ADDR_BASE(MAP0_BASE), .ADDR_MASK(MAP0_MASK), .TIMEOUT(255), .TW(8)
   ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

   sm_matrix_n #(
      .SLAVES(2), .ADDR_BASE(MAP1_BASE), .ADDR_MASK(MAP1_MASK), .TIMEOUT(4), .TW(3)
   ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      bus0.a = 32'h0000_1234; bus0.we = 1'b0; bus0.wd = '0; bus0.valid = 1'b0;
      bus0.s_ready = 2'b11; bus0.s_rd = {32'h1111_1111, 32'h2222_2222};
      bus1.a = '0; bus1.we = 1'b0; bus1.wd = '0; bus1.valid = 1'b0;
      bus1.s_ready = 2'b11; bus1.s_rd = {32'h3333_3333, 32'h4444_4444};
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if ({bus0.ready, bus0.err} !== 2'b00) begin n_bad++;
         $display("FAIL reset_rdy_err0: got %b want 00", {bus0.ready, bus0.err}); end
      n_cmp++; if (bus0.rd !== 32'h0) begin n_bad++;
         $display("FAIL reset_rd0: got %h want 0", bus0.rd); end
      n_cmp++; if (bus0.s_valid !== 2'b00) begin n_bad++;
         $display("FAIL reset_svalid0: got %b want 00", bus0.s_valid); end
      n_cmp++; if ({bus1.ready, bus1.err} !== 2'b00) begin n_bad++;
         $display("FAIL reset_rdy_err1: got %b want 00", {bus1.ready, bus1.err}); end
      n_cmp++; if (bus0.s_a !== 32'h0000_1234) begin n_bad++;
         $display("FAIL reset_s_a: got %h want 00001234", bus0.s_a); end
      @(negedge clk);
      rst_n = 1'b1; bus0.s_ready = '0; bus1.s_ready = '0;
      #1;
      n_cmp++; if (bus0.ready !== 1'b0) begin n_bad++;
         $display("FAIL post_reset_ready: got %b want 0", bus0.ready); end
   endtask

   task automatic test_read_spm();
      exp_t e;
      @(negedge clk);
      bus0.a = 32'h0000_0010; bus0.we = 1'b0; bus0.valid = 1'b1;
      bus0.s_rd = {32'hDEAD_BEEF, 32'h1234_5678};
      #1;
      n_cmp++; if (bus0.s_valid !== 2'b01) begin n_bad++;
         $display("FAIL rd_svalid: got %b want 01", bus0.s_valid); end
      n_cmp++; if (bus0.ready !== 1'b0) begin n_bad++;
         $display("FAIL rd_early_ready: got %b want 0", bus0.ready); end
      sb.push_back('{32'h1234_5678, 1'b0});
      @(negedge clk);
      bus0.s_ready = 2'b01;
      #1;
      n_cmp++; if (bus0.ready !== 1'b1) begin n_bad++;
         $display("FAIL rd_ready: got %b want 1", bus0.ready); end
      if (bus0.ready === 1'b1 && sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++; if ({bus0.rd, bus0.err} !== {e.rd, e.err}) begin n_bad++;
            $display("FAIL rd_resp: got %h/%b want %h/%b", bus0.rd, bus0.err, e.rd, e.err); end
      end
      n_cmp++; if (bus0.s_valid !== 2'b00) begin n_bad++;
         $display("FAIL rd_svalid_pulse: got %b want 00", bus0.s_valid); end
      @(negedge clk);
      bus0.valid = 1'b0; bus0.s_ready = '0;
      #1;
      n_cmp++; if ({bus0.ready, bus0.rd} !== 33'h0) begin n_bad++;
         $display("FAIL rd_after: got %b/%h want 0/0", bus0.ready, bus0.rd); end
   endtask

   task automatic test_write_ahb();
      exp_t e;
      int   n_rdy = 0, n_sv = 0, cyc = -1;
      @(negedge clk);
      bus0.a = 32'h2000_0000; bus0.we = 1'b1; bus0.wd = 32'hCAFE_F00D; bus0.valid = 1'b1;
      bus0.s_rd = {32'h5A5A_0001, 32'h0};
      #1;
      n_cmp++; if (bus0.s_valid !== 2'b10) begin n_bad++;
         $display("FAIL wr_svalid: got %b want 10", bus0.s_valid); end
      n_cmp++; if ({bus0.s_we, bus0.s_wd} !== {1'b1, 32'hCAFE_F00D}) begin n_bad++;
         $display("FAIL wr_data: got %b/%h want 1/cafef00d", bus0.s_we, bus0.s_wd); end
      sb.push_back('{32'h5A5A_0001, 1'b0});
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         bus0.s_ready = (c == 4) ? 2'b10 : 2'b00;
         if (c > 4) bus0.valid = 1'b0;
         #1;
         if (bus0.s_valid !== 2'b00) n_sv++;
         if (bus0.ready === 1'b1) begin
            n_rdy++;
            if (cyc < 0) cyc = c;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               n_cmp++; if ({bus0.rd, bus0.err} !== {e.rd, e.err}) begin n_bad++;
                  $display("FAIL wr_resp: got %h/%b want %h/%b", bus0.rd, bus0.err, e.rd, e.err); end
            end
         end
      end
      n_cmp++; if (cyc !== 4) begin n_bad++;
         $display("FAIL wr_latency: got cycle %0d want 4", cyc); end
      n_cmp++; if (n_rdy !== 1) begin n_bad++;
         $display("FAIL wr_ready_once: got %0d pulses want 1", n_rdy); end
      n_cmp++; if (n_sv !== 0) begin n_bad++;
         $display("FAIL wr_svalid_single: got %0d extra cycles want 0", n_sv); end
      bus0.we = 1'b0;
   endtask

   task automatic test_unmapped();
      exp_t e;
      @(negedge clk);
      bus1.a = 32'hF000_0000; bus1.valid = 1'b1; bus1.s_rd = {32'h9999_9999, 32'h8888_8888};
      #1;
      n_cmp++; if ({bus1.s_valid, bus1.ready} !== 3'b000) begin n_bad++;
         $display("FAIL um_issue: got %b/%b want 00/0", bus1.s_valid, bus1.ready); end
      sb.push_back('{32'h0, 1'b1});
      @(negedge clk);
      #1;
      n_cmp++; if (bus1.ready !== 1'b1) begin n_bad++;
         $display("FAIL um_ready: got %b want 1", bus1.ready); end
      if (bus1.ready === 1'b1 && sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++; if ({bus1.rd, bus1.err} !== {e.rd, e.err}) begin n_bad++;
            $display("FAIL um_resp: got %h/%b want %h/%b", bus1.rd, bus1.err, e.rd, e.err); end
      end
      n_cmp++; if (bus1.s_valid !== 2'b00) begin n_bad++;
         $display("FAIL um_svalid: got %b want 00", bus1.s_valid); end
      @(negedge clk);
      bus1.valid = 1'b0;
      #1;
      n_cmp++; if (bus1.ready !== 1'b0) begin n_bad++;
         $display("FAIL um_after: got %b want 0", bus1.ready); end
   endtask

   task automatic test_timeout();
      exp_t e;
      int   cyc = -1;
      @(negedge clk);
      bus1.a = 32'h2000_0004; bus1.valid = 1'b1; bus1.s_rd = {32'h7777_0002, 32'h6666_0002};
      #1;
      n_cmp++; if (bus1.s_valid !== 2'b10) begin n_bad++;
         $display("FAIL to_svalid: got %b want 10", bus1.s_valid); end
      sb.push_back('{32'h0, 1'b1});
      for (int c = 0; c < 10 && cyc < 0; c++) begin
         @(negedge clk);
         #1;
         if (bus1.ready === 1'b1) begin
            cyc = c;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               n_cmp++; if ({bus1.rd, bus1.err} !== {e.rd, e.err}) begin n_bad++;
                  $display("FAIL to_resp: got %h/%b want %h/%b", bus1.rd, bus1.err, e.rd, e.err); end
            end
         end
      end
      n_cmp++; if (cyc !== 3) begin n_bad++;
         $display("FAIL to_latency: got cycle %0d want 3", cyc); end
      @(negedge clk);
      bus1.valid = 1'b0;
      @(negedge clk);
      bus1.s_ready = 2'b10;
      #1;
      n_cmp++; if (bus1.ready !== 1'b0) begin n_bad++;
         $display("FAIL to_late_ignored: got %b want 0", bus1.ready); end
      @(negedge clk);
      bus1.s_ready = '0; bus1.a = 32'h0000_0040; bus1.valid = 1'b1;
      #1;
      n_cmp++; if (bus1.s_valid !== 2'b01) begin n_bad++;
         $display("FAIL to_next_issue: got %b want 01", bus1.s_valid); end
      sb.push_back('{32'h6666_0002, 1'b0});
      @(negedge clk);
      bus1.s_ready = 2'b01;
      #1;
      n_cmp++; if (bus1.ready !== 1'b1) begin n_bad++;
         $display("FAIL to_next_ready: got %b want 1", bus1.ready); end
      if (bus1.ready === 1'b1 && sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++; if ({bus1.rd, bus1.err} !== {e.rd, e.err}) begin n_bad++;
            $display("FAIL to_next_resp: got %h/%b want %h/%b", bus1.rd, bus1.err, e.rd, e.err); end
      end
      @(negedge clk);
      bus1.valid = 1'b0; bus1.s_ready = '0;
   endtask

   task automatic test_timeout_race();
      exp_t e;
      int   cyc = -1;
      @(negedge clk);
      bus1.a = 32'h2000_0100; bus1.valid = 1'b1; bus1.s_rd = {32'h7777_0001, 32'h0};
      #1;
      sb.push_back('{32'h7777_0001, 1'b0});
      for (int c = 0; c < 10 && cyc < 0; c++) begin
         @(negedge clk);
         bus1.s_ready = (c == 3) ? 2'b10 : 2'b00;
         #1;
         if (bus1.ready === 1'b1) begin
            cyc = c;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               n_cmp++; if ({bus1.rd, bus1.err} !== {e.rd, e.err}) begin n_bad++;
                  $display("FAIL race_resp: got %h/%b want %h/%b", bus1.rd, bus1.err, e.rd, e.err); end
            end
         end
      end
      n_cmp++; if (cyc !== 3) begin n_bad++;
         $display("FAIL race_latency: got cycle %0d want 3", cyc); end
      @(negedge clk);
      bus1.valid = 1'b0; bus1.s_ready = '0;
   endtask

   task automatic test_stray_ready();
      exp_t e;
      @(negedge clk);
      bus0.valid = 1'b0; bus0.s_ready = 2'b01; bus0.s_rd = {32'hBBBB_0001, 32'hAAAA_0000};
      #1;
      n_cmp++; if (bus0.ready !== 1'b0) begin n_bad++;
         $display("FAIL stray_idle0: got %b want 0", bus0.ready); end
      @(negedge clk);
      #1;
      n_cmp++; if (bus0.ready !== 1'b0) begin n_bad++;
         $display("FAIL stray_idle1: got %b want 0", bus0.ready); end
      @(negedge clk);
      bus0.a = 32'h3000_0000; bus0.valid = 1'b1;
      #1;
      n_cmp++; if ({bus0.s_valid, bus0.ready} !== 3'b100) begin n_bad++;
         $display("FAIL stray_issue: got %b/%b want 10/0", bus0.s_valid, bus0.ready); end
      sb.push_back('{32'hBBBB_0001, 1'b0});
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         #1;
         n_cmp++; if (bus0.ready !== 1'b0) begin n_bad++;
            $display("FAIL stray_busy%0d: got %b want 0", c, bus0.ready); end
      end
      @(negedge clk);
      bus0.s_ready = 2'b10;
      #1;
      n_cmp++; if (bus0.ready !== 1'b1) begin n_bad++;
         $display("FAIL stray_ready: got %b want 1", bus0.ready); end
      if (bus0.ready === 1'b1 && sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++; if ({bus0.rd, bus0.err} !== {e.rd, e.err}) begin n_bad++;
            $display("FAIL stray_resp: got %h/%b want %h/%b", bus0.rd, bus0.err, e.rd, e.err); end
      end
      @(negedge clk);
      bus0.valid = 1'b0; bus0.s_ready = '0;
   endtask

   task automatic test_reset_busy();
      exp_t e;
      @(negedge clk);
      bus0.a = 32'h0000_0020; bus0.valid = 1'b1;
      #1;
      n_cmp++; if (bus0.s_valid !== 2'b01) begin n_bad++;
         $display("FAIL rb_issue: got %b want 01", bus0.s_valid); end
      @(negedge clk);
      rst_n = 1'b0; bus0.valid = 1'b0; bus0.s_ready = 2'b01;
      #1;
      n_cmp++; if ({bus0.ready, bus0.err, bus0.rd, bus0.s_valid} !== 36'h0) begin n_bad++;
         $display("FAIL rb_outputs: got %b/%b/%h/%b want 0/0/0/00",
                  bus0.ready, bus0.err, bus0.rd, bus0.s_valid); end
      @(negedge clk);
      rst_n = 1'b1; bus0.s_ready = '0;
      #1;
      n_cmp++; if (bus0.ready !== 1'b0) begin n_bad++;
         $display("FAIL rb_released: got %b want 0", bus0.ready); end
      @(negedge clk);
      bus0.a = 32'h0000_0100; bus0.valid = 1'b1; bus0.s_rd = {32'h0, 32'h0F0F_0F0F};
      #1;
      n_cmp++; if (bus0.s_valid !== 2'b01) begin n_bad++;
         $display("FAIL rb_reissue: got %b want 01", bus0.s_valid); end
      sb.push_back('{32'h0F0F_0F0F, 1'b0});
      @(negedge clk);
      bus0.valid = 1'b0;
      #1;
      n_cmp++; if (bus0.ready !== 1'b0) begin n_bad++;
         $display("FAIL rb_wait: got %b want 0", bus0.ready); end
      @(negedge clk);
      bus0.s_ready = 2'b01;
      #1;
      n_cmp++; if (bus0.ready !== 1'b1) begin n_bad++;
         $display("FAIL rb_ready: got %b want 1", bus0.ready); end
      if (bus0.ready === 1'b1 && sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++; if ({bus0.rd, bus0.err} !== {e.rd, e.err}) begin n_bad++;
            $display("FAIL rb_resp: got %h/%b want %h/%b", bus0.rd, bus0.err, e.rd, e.err); end
      end
      @(negedge clk);
      bus0.s_ready = '0;
   endtask

   initial begin
      test_reset();
      test_read_spm();
      test_write_ahb();
      test_unmapped();
      test_timeout();
      test_timeout_race();
      test_stray_ready();
      test_reset_busy();
      n_cmp++; if (sb.size() !== 0) begin n_bad++;
         $display("FAIL sb_drained: got %0d pending want 0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
